// File: rtl/mem_stage_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mem_stage_ctrl
// Purpose  : MEM-stage controller driving a req/ack data bus and stalling upstream
// Revision : 1.0 - initial release
// ============================================================================
module mem_stage_ctrl #(
    parameter int unsigned ADDR_BASE = 1024,
    parameter int unsigned ADDR_W    = 10,
    parameter int unsigned TIMEOUT   = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wb_en_in,
    input  logic              mem_read_in,
    input  logic              mem_write_in,
    input  logic [3:0]        dest_in,
    input  logic [31:0]       alu_result_in,
    input  logic [31:0]       st_val_in,
    output logic              wb_en_out,
    output logic              mem_read_out,
    output logic [3:0]        dest_out,
    output logic [31:0]       alu_result_out,
    output logic [31:0]       mem_data_out,
    output logic              stall,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ack,
    output logic              bus_error
);

    localparam int unsigned       CNT_W  = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0]  C_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t              state_q;
    logic [CNT_W-1:0]    wait_cnt_q;
    logic [31:0]         data_q;
    logic                mem_req_q;
    logic                mem_we_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic [31:0]         mem_wdata_q;
    logic                bus_error_q;

    logic                w_access;
    logic [31:0]         w_byte_off;
    logic [ADDR_W-1:0]   mem_addr_d;

    assign w_access   = mem_read_in | mem_write_in;
    assign w_byte_off = alu_result_in - 32'(ADDR_BASE);
    assign mem_addr_d = ADDR_W'(w_byte_off >> 2);

    // DONE is the single release cycle that lets the frozen pipeline advance.
    assign stall          = w_access & (state_q != ST_DONE);
    assign wb_en_out      = wb_en_in & ~stall;
    assign mem_read_out   = mem_read_in & ~stall;
    assign dest_out       = dest_in;
    assign alu_result_out = alu_result_in;
    assign mem_data_out   = data_q;

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign bus_error = bus_error_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            wait_cnt_q  <= '0;
            data_q      <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            bus_error_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (w_access) begin
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= mem_write_in;
                        mem_addr_q  <= mem_addr_d;
                        mem_wdata_q <= st_val_in;
                        wait_cnt_q  <= '0;
                        state_q     <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (mem_ack) begin
                        mem_req_q <= 1'b0;
                        if (!mem_we_q) begin
                            data_q <= mem_rdata;
                        end
                        state_q <= ST_DONE;
                    end else if (wait_cnt_q == C_LAST) begin
                        // Abandon the access; the instruction retires with zero data.
                        mem_req_q   <= 1'b0;
                        bus_error_q <= 1'b1;
                        data_q      <= '0;
                        state_q     <= ST_DONE;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
